instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Multi-byte instruction fetch/assembly unit between the program counter and the decoder.
//   - Reads INSTR_BYTES consecutive bytes from byte-addressable synchronous ROM.
//   - Assembles them little-endian into one instruction word.
//   - Holds the word stable in an output register until the decoder accepts it (valid/ready).
//   - Adds pipelined reads, address wrap and flush/abort; the program counter and the FSM drive it.
// PARAMETERS
//   ADDRESS_WIDTH  8  byte address width; ROM depth = 2**ADDRESS_WIDTH
//   DATA_WIDTH     8  memory byte/datapath width
//   INSTR_BYTES    2  bytes per instruction (>=1); instr width = DATA_WIDTH*INSTR_BYTES
// PORTS
//   clk          in   1                        system clock, rising edge
//   rst_n        in   1                        asynchronous active-low reset
//   fetch_start  in   1                        request fetch at fetch_addr (sampled only in IDLE)
//   fetch_addr   in   ADDRESS_WIDTH            byte address of instruction's low byte
//   flush        in   1                        abort in-flight fetch, discard held instruction
//   mem_rd_en    out  1                        registered ROM read strobe
//   mem_addr     out  ADDRESS_WIDTH            registered ROM byte address
//   mem_rdata    in   DATA_WIDTH               ROM data, valid the cycle after mem_rd_en high
//   instr        out  DATA_WIDTH*INSTR_BYTES   assembled instruction (registered)
//   instr_addr   out  ADDRESS_WIDTH            fetch_addr of the held instruction
//   next_addr    out  ADDRESS_WIDTH            instr_addr + INSTR_BYTES, modulo 2**ADDRESS_WIDTH
//   instr_valid  out  1                        instr/instr_addr/next_addr valid and stable
//   instr_ready  in   1                        decoder accepts instr when instr_valid high
//   busy         out  1                        high in READ state
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; all outputs 0; byte/issue counters 0.
//   States:
//     IDLE: fetch_start=1 at edge T -> READ; latch fetch_addr; mem_addr<=fetch_addr; mem_rd_en<=1.
//     READ: one read issued per cycle, mem_addr increments by 1 mod 2**ADDRESS_WIDTH.
//       - mem_rd_en is high for exactly INSTR_BYTES cycles (after edges T..T+N-1, N=INSTR_BYTES).
//       - Byte k is sampled at edge T+2+k into bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
//       - At edge T+N+1 -> HOLD; instr_valid<=1.
//       - Fetch latency = N+1 cycles from accepted start to instr_valid.
//     HOLD: instr, instr_addr and next_addr are frozen.
//       - instr_valid && instr_ready at an edge: instr_valid<=0, -> IDLE.
//       - If fetch_start=1 at that same edge, it is accepted (back-to-back) -> READ.
//   - Assembly happens in a shadow register; the instr output updates only on the HOLD entry edge.
//     The previous instruction stays visible (instr_valid=0) while READ runs.
//   - fetch_start while busy or while instr_valid && !instr_ready: ignored, no queueing.
//   - Address wrap: bytes crossing the top address wrap to 0.
//     Example: ADDRESS_WIDTH=8, addr 0xFF -> bytes 0xFF, 0x00.
//   flush (synchronous, highest priority):
//     - Next state IDLE; mem_rd_en<=0; instr_valid<=0.
//     - Pending mem_rdata is discarded; instr keeps its old value.
//     - flush with fetch_start in the same cycle: flush wins, start dropped.
//   Reset asserted mid-fetch: immediate return to reset values; no partial instruction is ever exposed.
//   busy = (state==READ). instr_valid never high in READ.
// TESTING
//   1. ROM[0x00]=0x14, ROM[0x01]=0x05; fetch_start, addr 0x00, ready=1
//      -> instr=0x0514 valid 3 cycles after start, next_addr=0x02.
//   2. ready=0 for 5 cycles after valid -> instr/instr_valid stable.
//      Extra fetch_start ignored (mem_rd_en stays 0). ready=1 -> valid drops next cycle.
//   3. Handshake edge coincides with fetch_start addr 0x02 (ROM 0x0C, 0x03)
//      -> no idle cycle; next instr=0x030C.
//   4. Start at 0xFF, ROM[0xFF]=0xAA, ROM[0x00]=0x14 -> mem_addr 0xFF then 0x00,
//      instr=0x14AA, next_addr=0x01.
//   5. flush one cycle after start -> mem_rd_en low next cycle, no instr_valid,
//      instr unchanged; flush+start same cycle -> start dropped.
//   6. rst_n low mid-READ -> all outputs 0 immediately; INSTR_BYTES=3, DATA_WIDTH=8 rerun of (1)
//      with ROM[2]=0x0C -> instr=0x0C0514, valid after 4 cycles.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetches INSTR_BYTES bytes from a synchronous ROM with pipelined
//            reads, assembles them little-endian and holds the instruction
//            under a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int INSTR_BYTES   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fetch_start,
    input  logic [ADDRESS_WIDTH-1:0]          fetch_addr,
    input  logic                              flush,
    output logic                              mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic [DATA_WIDTH*INSTR_BYTES-1:0] instr,
    output logic [ADDRESS_WIDTH-1:0]          instr_addr,
    output logic [ADDRESS_WIDTH-1:0]          next_addr,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    output logic                              busy
);

    localparam int INSTR_WIDTH = DATA_WIDTH * INSTR_BYTES;
    localparam int CNT_W       = $clog2(INSTR_BYTES + 1);

    localparam logic [CNT_W-1:0]         c_N_BYTES   = CNT_W'(INSTR_BYTES);
    localparam logic [CNT_W-1:0]         c_LAST_BYTE = CNT_W'(INSTR_BYTES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_STEP = ADDRESS_WIDTH'(INSTR_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_ONE  = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e                   state_q,       state_d;
    logic                     mem_rd_en_q,   mem_rd_en_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q,    mem_addr_d;
    logic                     rdata_vld_q,   rdata_vld_d;
    logic [CNT_W-1:0]         issue_cnt_q,   issue_cnt_d;
    logic [CNT_W-1:0]         byte_cnt_q,    byte_cnt_d;
    logic [ADDRESS_WIDTH-1:0] base_addr_q,   base_addr_d;
    logic [INSTR_WIDTH-1:0]   shadow_q,      shadow_d;
    logic [INSTR_WIDTH-1:0]   instr_q,       instr_d;
    logic [ADDRESS_WIDTH-1:0] instr_addr_q,  instr_addr_d;
    logic [ADDRESS_WIDTH-1:0] next_addr_q,   next_addr_d;
    logic                     instr_valid_q, instr_valid_d;

    logic [INSTR_WIDTH-1:0]   w_shadow_ins;
    logic                     w_accept;

    // Shadow word with the byte returning this cycle merged into its lane.
    always_comb begin
        w_shadow_ins = shadow_q;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
                w_shadow_ins[k*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_addr_d    = mem_addr_q;
        rdata_vld_d   = mem_rd_en_q;
        issue_cnt_d   = issue_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        base_addr_d   = base_addr_q;
        shadow_d      = shadow_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        next_addr_d   = next_addr_q;
        instr_valid_d = instr_valid_q;
        w_accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    w_accept = 1'b1;
                end
            end
            S_READ: begin
                if (issue_cnt_q < c_N_BYTES) begin
                    mem_addr_d  = mem_addr_q + c_ADDR_ONE;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end else begin
                    mem_rd_en_d = 1'b0;
                end
                if (rdata_vld_q) begin
                    shadow_d = w_shadow_ins;
                    if (byte_cnt_q == c_LAST_BYTE) begin
                        state_d       = S_HOLD;
                        instr_d       = w_shadow_ins;
                        instr_addr_d  = base_addr_q;
                        next_addr_d   = base_addr_q + c_ADDR_STEP;
                        instr_valid_d = 1'b1;
                        byte_cnt_d    = '0;
                        issue_cnt_d   = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                    if (fetch_start) begin
                        w_accept = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_accept) begin
            state_d     = S_READ;
            base_addr_d = fetch_addr;
            mem_addr_d  = fetch_addr;
            mem_rd_en_d = 1'b1;
            issue_cnt_d = CNT_W'(1);
            byte_cnt_d  = '0;
        end

        // Flush overrides everything, including a start in the same cycle.
        if (flush) begin
            state_d       = S_IDLE;
            mem_rd_en_d   = 1'b0;
            rdata_vld_d   = 1'b0;
            instr_valid_d = 1'b0;
            issue_cnt_d   = '0;
            byte_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            rdata_vld_q   <= 1'b0;
            issue_cnt_q   <= '0;
            byte_cnt_q    <= '0;
            base_addr_q   <= '0;
            shadow_q      <= '0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            next_addr_q   <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            rdata_vld_q   <= rdata_vld_d;
            issue_cnt_q   <= issue_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            base_addr_q   <= base_addr_d;
            shadow_q      <= shadow_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            next_addr_q   <= next_addr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign next_addr   = next_addr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q == S_READ);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit (2- and 3-byte).
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fetch_start, flush, instr_ready;
    logic [7:0]  fetch_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic [7:0]  instr_addr, next_addr;
    logic        instr_valid, busy;

    logic        fs3, fl3, rdy3;
    logic [7:0]  fa3;
    logic        rd3;
    logic [7:0]  ma3, rdata3;
    logic [23:0] instr3;
    logic [7:0]  ia3, na3;
    logic        v3, busy3;

    instr_fetch_unit #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .INSTR_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .fetch_addr(fetch_addr),
        .flush(flush), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .instr_addr(instr_addr), .next_addr(next_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy)
    );

    instr_fetch_unit #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .INSTR_BYTES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs3), .fetch_addr(fa3),
        .flush(fl3), .mem_rd_en(rd3), .mem_addr(ma3), .mem_rdata(rdata3),
        .instr(instr3), .instr_addr(ia3), .next_addr(na3),
        .instr_valid(v3), .instr_ready(rdy3), .busy(busy3)
    );

    // Synchronous ROM shared by both instances.
    logic [7:0] rom [256];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= rom[mem_addr];
        if (rd3)       rdata3    <= rom[ma3];
    end

    typedef struct packed {
        logic [23:0] instr;
        logic [7:0]  addr;
        logic [7:0]  nxt;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [7:0] a, input logic [15:0] ei);
        exp_t        e;
        logic [15:0] prev;
        int          n;
        int          rd;
        e.instr = {8'h00, ei};
        e.addr  = a;
        e.nxt   = a + 8'd2;
        sb.push_back(e);
        prev        = instr;
        fetch_start = 1'b1;
        fetch_addr  = a;
        tick();
        fetch_start = 1'b0;
        chk("start_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("start_mem_addr", {24'd0, mem_addr}, {24'd0, a});
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("read_valid_low", {31'd0, instr_valid}, 32'd0);
        chk("read_instr_held", {16'd0, instr}, {16'd0, prev});
        n  = 0;
        rd = 1;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
            rd += int'(mem_rd_en);
            if (n == 1) chk("second_mem_addr", {24'd0, mem_addr}, {24'd0, a + 8'd1});
        end
        chk("latency", n, 32'd3);
        chk("rd_en_cycles", rd, 32'd2);
        chk("hold_busy_low", {31'd0, busy}, 32'd0);
        e = sb.pop_front();
        chk("instr", {16'd0, instr}, {8'd0, e.instr});
        chk("instr_addr", {24'd0, instr_addr}, {24'd0, e.addr});
        chk("next_addr", {24'd0, next_addr}, {24'd0, e.nxt});
    endtask

    initial begin
        logic [15:0] prev;
        exp_t        e3;
        int          n;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        rom[8'h00] = 8'h14;
        rom[8'h01] = 8'h05;
        rom[8'h02] = 8'h0C;
        rom[8'h03] = 8'h03;
        rom[8'hFF] = 8'hAA;

        rst_n = 1'b0;
        fetch_start = 1'b0; fetch_addr = 8'h00; flush = 1'b0; instr_ready = 1'b0;
        fs3 = 1'b0; fa3 = 8'h00; fl3 = 1'b0; rdy3 = 1'b0;
        tick();
        tick();
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_next_addr", {24'd0, next_addr}, 32'd0);
        chk("rst_instr3", {8'd0, instr3}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic fetch, ready already high: valid drops one cycle later.
        instr_ready = 1'b1;
        do_fetch(8'h00, 16'h0514);
        tick();
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Decoder stalls; extra starts are ignored while held.
        instr_ready = 1'b0;
        do_fetch(8'h00, 16'h0514);
        for (int i = 0; i < 5; i++) begin
            fetch_start = 1'b1;
            fetch_addr  = 8'h40;
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", {16'd0, instr}, 32'h0514);
            chk("stall_rd_en", {31'd0, mem_rd_en}, 32'd0);
        end
        fetch_start = 1'b0;

        // Back-to-back: handshake edge also accepts the next start.
        instr_ready = 1'b1;
        do_fetch(8'h02, 16'h030C);
        tick();

        // Address wrap across the top of the ROM.
        do_fetch(8'hFF, 16'h14AA);
        tick();

        // Flush one cycle after start.
        prev        = instr;
        fetch_start = 1'b1;
        fetch_addr  = 8'h02;
        tick();
        fetch_start = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("flush_instr", {16'd0, instr}, {16'd0, prev});
        for (int i = 0; i < 4; i++) tick();
        chk("post_flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_flush_instr", {16'd0, instr}, {16'd0, prev});

        // Flush and start together: start dropped.
        flush       = 1'b1;
        fetch_start = 1'b1;
        fetch_addr  = 8'h00;
        tick();
        flush       = 1'b0;
        fetch_start = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        chk("flush_start_rd_en", {31'd0, mem_rd_en}, 32'd0);
        tick();
        chk("flush_start_idle", {31'd0, busy}, 32'd0);

        do_fetch(8'h02, 16'h030C);
        tick();

        // Asynchronous reset mid-READ.
        fetch_start = 1'b1;
        fetch_addr  = 8'h00;
        tick();
        fetch_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_instr", {16'd0, instr}, 32'd0);
        chk("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("arst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_instr_addr", {24'd0, instr_addr}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Three-byte instance.
        e3.instr = 24'h0C0514;
        e3.addr  = 8'h00;
        e3.nxt   = 8'h03;
        sb.push_back(e3);
        rdy3 = 1'b1;
        fs3  = 1'b1;
        fa3  = 8'h00;
        tick();
        fs3 = 1'b0;
        n = 0;
        while (!v3 && n < 20) begin
            tick();
            n++;
        end
        e3 = sb.pop_front();
        chk("latency3", n, 32'd4);
        chk("instr3", {8'd0, instr3}, {8'd0, e3.instr});
        chk("instr_addr3", {24'd0, ia3}, {24'd0, e3.addr});
        chk("next_addr3", {24'd0, na3}, {24'd0, e3.nxt});
        tick();
        chk("valid_drop3", {31'd0, v3}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
